// File: rtl/ssm2603_pkg.sv
// Shared definitions for the SSM2603 I2S ADC receiver: FSM encoding,
// default sample width and the I2S slot width.
package ssm2603_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int I2S_CH_W   = 32;

    localparam logic [1:0] ST_HUNT  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAD   = 2'd2;

    // Single-cycle rising-edge detect on a synchronized level.
    function automatic logic rise_det(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/ssm2603_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-low clear.
module ssm2603_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    generate
        if (SYNC_STAGES == 1) begin : g_one
            // Single-stage capture
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_sync <= 1'b0;
                end else begin
                    r_sync <= i_d;
                end
            end
        end else begin : g_many
            // Shift chain, oldest sample at the MSB
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_sync <= {SYNC_STAGES{1'b0}};
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
                end
            end
        end
    endgenerate

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ssm2603_adc_rx.sv
// I2S receiver for the SSM2603 ADC path: oversamples BCLK/LRCK/DAT on CLK,
// deserializes left/right words and presents them as a valid/ready pair.
module ssm2603_adc_rx
    import ssm2603_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              AUD_BCLK,
    input  logic              AUD_ADCLRCK,
    input  logic              AUD_ADCDAT,
    output logic [DATA_W-1:0] SAMPLE_L,
    output logic [DATA_W-1:0] SAMPLE_R,
    output logic              SAMPLE_VALID,
    input  logic              SAMPLE_READY,
    output logic              OVERRUN,
    output logic              FRAME_ERR
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              w_bclk_s;
    logic              w_lrck_s;
    logic              w_dat_s;
    logic              w_tick;
    logic              w_lrck_edge;
    logic [DATA_W-1:0] w_word;
    logic              w_last_bit;
    logic              w_pair_done;
    logic              w_short;

    logic [1:0]        w_state_nxt;
    logic              w_chan_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [DATA_W-1:0] w_left_nxt;
    logic              w_left_vld_nxt;

    logic              r_bclk_d;
    logic              r_lrck_prev;
    logic [1:0]        r_state;
    logic              r_chan;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_left;
    logic              r_left_valid;
    logic [DATA_W-1:0] r_sample_l;
    logic [DATA_W-1:0] r_sample_r;
    logic              r_sample_valid;
    logic              r_overrun;
    logic              r_frame_err;

    ssm2603_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_d     (AUD_BCLK),
        .o_q     (w_bclk_s)
    );

    ssm2603_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_d     (AUD_ADCLRCK),
        .o_q     (w_lrck_s)
    );

    ssm2603_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_d     (AUD_ADCDAT),
        .o_q     (w_dat_s)
    );

    assign w_tick      = rise_det(w_bclk_s, r_bclk_d);
    assign w_lrck_edge = w_tick && (w_lrck_s != r_lrck_prev);
    assign w_word      = {r_shift[DATA_W-2:0], w_dat_s};
    assign w_last_bit  = w_tick && (r_state == ST_SHIFT) && !w_lrck_edge
                         && (r_cnt == CNT_W'(DATA_W - 1));
    assign w_pair_done = w_last_bit && r_chan && r_left_valid;
    assign w_short     = w_tick && w_lrck_edge && (r_state == ST_SHIFT);

    // BCLK edge history and LRCK value from the previous bit tick
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_bclk_d    <= 1'b0;
            r_lrck_prev <= 1'b0;
        end else begin
            r_bclk_d <= w_bclk_s;
            if (w_tick) begin
                r_lrck_prev <= w_lrck_s;
            end else begin
                r_lrck_prev <= r_lrck_prev;
            end
        end
    end

    // Frame FSM; the bit on the LRCK edge tick is the I2S delay slot and is dropped
    always_comb begin
        w_state_nxt    = r_state;
        w_chan_nxt     = r_chan;
        w_cnt_nxt      = r_cnt;
        w_shift_nxt    = r_shift;
        w_left_nxt     = r_left;
        w_left_vld_nxt = r_left_valid;
        if (w_tick) begin
            case (r_state)
                ST_HUNT: begin
                    if (w_lrck_edge && !w_lrck_s) begin
                        w_state_nxt = ST_SHIFT;
                        w_chan_nxt  = 1'b0;
                        w_cnt_nxt   = {CNT_W{1'b0}};
                    end else begin
                        w_state_nxt = ST_HUNT;
                    end
                end
                ST_SHIFT: begin
                    if (w_lrck_edge) begin
                        // Short channel: resynchronize on the next left edge
                        w_state_nxt    = ST_HUNT;
                        w_cnt_nxt      = {CNT_W{1'b0}};
                        w_left_vld_nxt = 1'b0;
                    end else begin
                        w_shift_nxt = w_word;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                        if (w_last_bit) begin
                            w_state_nxt = ST_PAD;
                            if (!r_chan) begin
                                w_left_nxt     = w_word;
                                w_left_vld_nxt = 1'b1;
                            end else begin
                                w_left_vld_nxt = 1'b0;
                            end
                        end else begin
                            w_state_nxt = ST_SHIFT;
                        end
                    end
                end
                ST_PAD: begin
                    if (w_lrck_edge) begin
                        w_state_nxt = ST_SHIFT;
                        w_chan_nxt  = ~r_chan;
                        w_cnt_nxt   = {CNT_W{1'b0}};
                    end else begin
                        w_state_nxt = ST_PAD;
                    end
                end
                default: begin
                    w_state_nxt    = ST_HUNT;
                    w_left_vld_nxt = 1'b0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // FSM and deserializer state registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= ST_HUNT;
            r_chan       <= 1'b0;
            r_cnt        <= {CNT_W{1'b0}};
            r_shift      <= {DATA_W{1'b0}};
            r_left       <= {DATA_W{1'b0}};
            r_left_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_chan       <= w_chan_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_left       <= w_left_nxt;
            r_left_valid <= w_left_vld_nxt;
        end
    end

    // Output holding register with valid/ready handshake and error pulses
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sample_l     <= {DATA_W{1'b0}};
            r_sample_r     <= {DATA_W{1'b0}};
            r_sample_valid <= 1'b0;
            r_overrun      <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_frame_err <= w_short;
            if (w_pair_done) begin
                if (!r_sample_valid || SAMPLE_READY) begin
                    r_sample_l     <= r_left;
                    r_sample_r     <= w_word;
                    r_sample_valid <= 1'b1;
                    r_overrun      <= 1'b0;
                end else begin
                    r_sample_valid <= 1'b1;
                    r_overrun      <= 1'b1;
                end
            end else if (r_sample_valid && SAMPLE_READY) begin
                r_sample_valid <= 1'b0;
                r_overrun      <= 1'b0;
            end else begin
                r_sample_valid <= r_sample_valid;
                r_overrun      <= 1'b0;
            end
        end
    end

    assign SAMPLE_L     = r_sample_l;
    assign SAMPLE_R     = r_sample_r;
    assign SAMPLE_VALID = r_sample_valid;
    assign OVERRUN      = r_overrun;
    assign FRAME_ERR    = r_frame_err;

endmodule

// File: tb/tb_ssm2603_adc_rx.sv
// Scoreboard bench for ssm2603_adc_rx: drives I2S frames with BCLK = CLK/4
// and compares every accepted pair against the queued expectation.
module tb_ssm2603_adc_rx;

    localparam int DW = 16;
    localparam int SS = 2;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          AUD_BCLK;
    logic          AUD_ADCLRCK;
    logic          AUD_ADCDAT;
    logic [DW-1:0] SAMPLE_L;
    logic [DW-1:0] SAMPLE_R;
    logic          SAMPLE_VALID;
    logic          SAMPLE_READY;
    logic          OVERRUN;
    logic          FRAME_ERR;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lsb_cyc  = 0;
    int          ov_cnt   = 0;
    int          fe_cnt   = 0;
    int          pops     = 0;
    int          pushes   = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] exp_q[$];

    ssm2603_adc_rx #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .AUD_BCLK     (AUD_BCLK),
        .AUD_ADCLRCK  (AUD_ADCLRCK),
        .AUD_ADCDAT   (AUD_ADCDAT),
        .SAMPLE_L     (SAMPLE_L),
        .SAMPLE_R     (SAMPLE_R),
        .SAMPLE_VALID (SAMPLE_VALID),
        .SAMPLE_READY (SAMPLE_READY),
        .OVERRUN      (OVERRUN),
        .FRAME_ERR    (FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Output monitor, sampled just after the falling CLK edge
    always begin
        @(negedge CLK);
        #1;
        if (OVERRUN)   ov_cnt++;
        if (FRAME_ERR) fe_cnt++;
        if (SAMPLE_VALID && !prev_valid)
            check_val("latency", 32'(cyc - lsb_cyc), 32'(SS + 1));
        if (SAMPLE_VALID && SAMPLE_READY) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_pair", 32'(exp_q.size()), 32'd1);
            end else begin
                check_val("pair", {SAMPLE_L, SAMPLE_R}, exp_q.pop_front());
                pops++;
            end
        end
        prev_valid = SAMPLE_VALID;
    end

    initial begin
        repeat (60000) @(posedge CLK);
        $display("FAIL watchdog: cycles=%0d limit=60000", cyc);
        $fatal(1);
    end

    task automatic send_bit(input logic lr, input logic d, input bit mark);
        @(negedge CLK);
        AUD_BCLK    = 1'b0;
        AUD_ADCLRCK = lr;
        AUD_ADCDAT  = d;
        @(negedge CLK);
        @(negedge CLK);
        AUD_BCLK = 1'b1;
        if (mark) lsb_cyc = cyc;
        @(negedge CLK);
    endtask

    // One channel: delay bit, DW data bits MSB first, then random pad up to clen
    task automatic send_chan(input logic lr, input logic [DW-1:0] w, input int clen, input bit mark);
        logic d;
        for (int b = 0; b < clen; b++) begin
            if (b >= 1 && b <= DW) d = w[DW-b];
            else d = 1'($urandom_range(0, 1));
            send_bit(lr, d, mark && (b == DW));
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit expect_out);
        if (expect_out) begin
            exp_q.push_back({l, r});
            pushes++;
        end
        send_chan(1'b0, l, 32, 1'b0);
        send_chan(1'b1, r, 32, expect_out);
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    initial begin
        RESET_N      = 1'b0;
        AUD_BCLK     = 1'b0;
        AUD_ADCLRCK  = 1'b1;
        AUD_ADCDAT   = 1'b0;
        SAMPLE_READY = 1'b1;
        repeat (3) @(negedge CLK);
        check_val("rst_l",     32'(SAMPLE_L), 32'd0);
        check_val("rst_r",     32'(SAMPLE_R), 32'd0);
        check_val("rst_valid", 32'(SAMPLE_VALID), 32'd0);
        check_val("rst_ovr",   32'(OVERRUN), 32'd0);
        check_val("rst_ferr",  32'(FRAME_ERR), 32'd0);
        RESET_N = 1'b1;

        // Basic frame after a short right-channel tail
        send_chan(1'b1, 16'h0000, 4, 1'b0);
        send_frame(16'hA5C3, 16'h5A3C, 1'b1);

        // Consumer stalled over two frames
        @(negedge CLK);
        SAMPLE_READY = 1'b0;
        ov_cnt = 0;
        send_frame(16'h1111, 16'h2222, 1'b1);
        send_frame(16'h3333, 16'h4444, 1'b0);
        repeat (4) @(negedge CLK);
        check_val("ovr_count", 32'(ov_cnt), 32'd1);
        check_val("held_pair", {SAMPLE_L, SAMPLE_R}, 32'h1111_2222);
        check_val("held_valid", 32'(SAMPLE_VALID), 32'd1);
        SAMPLE_READY = 1'b1;
        repeat (4) @(negedge CLK);
        check_val("valid_clear", 32'(SAMPLE_VALID), 32'd0);
        check_val("hold_after_accept", {SAMPLE_L, SAMPLE_R}, 32'h1111_2222);

        // Short left channel
        fe_cnt = 0;
        send_chan(1'b0, 16'hFFFF, 10, 1'b0);
        send_chan(1'b1, 16'hFFFF, 32, 1'b0);
        check_val("ferr_count", 32'(fe_cnt), 32'd1);
        send_frame(16'h0F0F, 16'hF0F0, 1'b1);
        check_val("ferr_once", 32'(fe_cnt), 32'd1);

        // Stream joined mid right channel
        pulse_reset();
        send_chan(1'b1, 16'h1234, 20, 1'b0);
        send_frame(16'h8000, 16'h7FFF, 1'b1);
        repeat (8) @(negedge CLK);
        check_val("midright_drain", 32'(exp_q.size()), 32'd0);

        // Reset during left-channel shift
        send_chan(1'b0, 16'hBEEF, 8, 1'b0);
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check_val("mid_rst_l",     32'(SAMPLE_L), 32'd0);
        check_val("mid_rst_r",     32'(SAMPLE_R), 32'd0);
        check_val("mid_rst_valid", 32'(SAMPLE_VALID), 32'd0);
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        send_chan(1'b1, 16'h0000, 4, 1'b0);
        send_frame(16'h0123, 16'h4567, 1'b1);

        // Back-to-back frames with an always-ready consumer
        ov_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            send_frame(16'(16'h1000 + 2 * i), 16'(16'h1001 + 2 * i), 1'b1);
        end
        repeat (8) @(negedge CLK);
        check_val("final_drain", 32'(exp_q.size()), 32'd0);
        check_val("b2b_ovr", 32'(ov_cnt), 32'd0);
        check_val("pop_count", 32'(pops), 32'(pushes));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
